bar_buffer_ctrl: RTL and testbench

Double-buffered controller between the upstream 16-bin signed sample stream (spectrum/level bins) and the 640x480 bar display generator. It captures one 16-bin frame into a back bank using a valid/ready handshake. It swaps banks only at the start of vertical sync, so the display never tears mid-frame. The display generator reads the front bank through a 4-bit combinational read port, with rd_addr = h_count/40.

---
 rtl/bar_buffer_ctrl.sv | 136 +++++++++++++
 tb/tb_bar_buffer_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bar_buffer_ctrl.sv
// Double-buffered 16-bin frame store between the sample stream and the bar display.
// The back bank fills over a valid/ready handshake; banks swap only on a vsync falling edge.
module bar_buffer_ctrl #(
    parameter int DATA_WIDTH = 24,
    parameter int NUM_BINS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  vsync,
    input  logic                  freeze,
    input  logic [3:0]            rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  swap_pulse,
    output logic [7:0]            frames_shown,
    output logic [7:0]            resync_errs
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t                state_r, state_s;
    logic [3:0]            wr_idx_r, wr_idx_s;
    logic [DATA_WIDTH-1:0] bank_r [2][NUM_BINS];
    logic                  front_sel_r;
    logic                  vsync_d_r;
    logic                  swap_pulse_r;
    logic [7:0]            frames_shown_r;
    logic [7:0]            resync_errs_r;

    logic                  accept_s;
    logic                  vs_fall_s;
    logic                  swap_s;
    logic                  wr_en_s;
    logic [3:0]            wr_addr_s;
    logic                  resync_s;

    assign in_ready     = ~rst & (state_r != ST_FULL);
    assign accept_s     = in_valid & in_ready;
    assign vs_fall_s    = vsync_d_r & ~vsync;
    assign swap_s       = vs_fall_s & (state_r == ST_FULL) & ~freeze;
    assign rd_data      = bank_r[front_sel_r][rd_addr];
    assign swap_pulse   = swap_pulse_r;
    assign frames_shown = frames_shown_r;
    assign resync_errs  = resync_errs_r;

    // Write FSM next-state: decides which back-bank entry (if any) is written this cycle.
    always_comb begin
        state_s   = state_r;
        wr_idx_s  = wr_idx_r;
        wr_en_s   = 1'b0;
        wr_addr_s = 4'd0;
        resync_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && in_sof) begin
                    wr_en_s  = 1'b1;
                    wr_idx_s = 4'd1;
                    state_s  = ST_FILL;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (accept_s && in_sof) begin
                    // Mid-frame sof restarts the frame at bin 0
                    wr_en_s  = 1'b1;
                    wr_idx_s = 4'd1;
                    resync_s = 1'b1;
                end else if (accept_s) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = wr_idx_r;
                    if (wr_idx_r == 4'(NUM_BINS - 1)) begin
                        wr_idx_s = 4'd0;
                        state_s  = ST_FULL;
                    end else begin
                        wr_idx_s = wr_idx_r + 4'd1;
                    end
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_FULL: begin
                if (swap_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FULL;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                wr_idx_s = 4'd0;
            end
        endcase
    end

    // State, bank storage, swap bookkeeping and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            wr_idx_r       <= 4'd0;
            front_sel_r    <= 1'b0;
            vsync_d_r      <= 1'b1;
            swap_pulse_r   <= 1'b0;
            frames_shown_r <= 8'd0;
            resync_errs_r  <= 8'd0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NUM_BINS; i++) begin
                    bank_r[b][i] <= {DATA_WIDTH{1'b0}};
                end
            end
        end else begin
            state_r      <= state_s;
            wr_idx_r     <= wr_idx_s;
            vsync_d_r    <= vsync;
            swap_pulse_r <= swap_s;
            if (wr_en_s) begin
                bank_r[~front_sel_r][wr_addr_s] <= in_data;
            end
            if (swap_s) begin
                front_sel_r    <= ~front_sel_r;
                frames_shown_r <= frames_shown_r + 8'd1;
            end
            if (resync_s && (resync_errs_r != 8'hFF)) begin
                resync_errs_r <= resync_errs_r + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_bar_buffer_ctrl.sv
// Directed bench for bar_buffer_ctrl: a cycle table for the first frame, then
// hand-written sequences for the stall, resync, freeze, reset and edge-coincidence cases.
module tb_bar_buffer_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_sof;
    logic [23:0] in_data;
    logic        in_ready;
    logic        vsync;
    logic        freeze;
    logic [3:0]  rd_addr;
    logic [23:0] rd_data;
    logic        swap_pulse;
    logic [7:0]  frames_shown;
    logic [7:0]  resync_errs;

    int n_chk  = 0;
    int n_fail = 0;

    bar_buffer_ctrl #(.DATA_WIDTH(24), .NUM_BINS(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .in_ready(in_ready), .vsync(vsync), .freeze(freeze), .rd_addr(rd_addr),
        .rd_data(rd_data), .swap_pulse(swap_pulse), .frames_shown(frames_shown),
        .resync_errs(resync_errs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        s;
        logic [23:0] d;
        logic        vs;
        logic [3:0]  ra;
        logic        e_rdy;
        logic [23:0] e_rd;
        logic        e_sw;
        logic [7:0]  e_fr;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [23:0] d, input logic s);
        in_valid = 1'b1;
        in_sof   = s;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    // One vsync low/high pulse; sw reports swap_pulse in the cycle after the falling edge.
    task automatic vs_edge(output logic sw);
        vsync = 1'b0;
        tick();
        sw = swap_pulse;
        vsync = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        chk("ready_in_reset", {31'd0, in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic rd_chk(input string nm, input logic [3:0] a, input logic [23:0] exp);
        rd_addr = a;
        #1;
        chk(nm, {8'd0, rd_data}, {8'd0, exp});
    endtask

    logic sw;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = 24'd0;
        vsync = 1'b1; freeze = 1'b0; rd_addr = 4'd0;

        for (int i = 0; i < 16; i++) begin
            tbl[i] = '{v: 1'b1, s: (i == 0), d: 24'(i * 1000), vs: 1'b1, ra: 4'd7,
                       e_rdy: 1'b1, e_rd: 24'd0, e_sw: 1'b0, e_fr: 8'd0};
        end
        tbl[16] = '{v: 1'b0, s: 1'b0, d: 24'd0, vs: 1'b0, ra: 4'd7,
                    e_rdy: 1'b0, e_rd: 24'd0, e_sw: 1'b0, e_fr: 8'd0};
        tbl[17] = '{v: 1'b0, s: 1'b0, d: 24'd0, vs: 1'b0, ra: 4'd7,
                    e_rdy: 1'b1, e_rd: 24'd7000, e_sw: 1'b1, e_fr: 8'd1};
        tbl[18] = '{v: 1'b0, s: 1'b0, d: 24'd0, vs: 1'b1, ra: 4'd7,
                    e_rdy: 1'b1, e_rd: 24'd7000, e_sw: 1'b0, e_fr: 8'd1};

        // Reset state
        tick();
        chk("ready_in_reset0", {31'd0, in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_rd", {8'd0, rd_data}, 32'd0);
        chk("rst_swap", {31'd0, swap_pulse}, 32'd0);
        chk("rst_frames", {24'd0, frames_shown}, 32'd0);
        chk("rst_resync", {24'd0, resync_errs}, 32'd0);

        // 1: first frame and swap, one record per cycle
        for (int k = 0; k < 19; k++) begin
            in_valid = tbl[k].v; in_sof = tbl[k].s; in_data = tbl[k].d;
            vsync = tbl[k].vs; rd_addr = tbl[k].ra;
            #1;
            chk($sformatf("t1_ready[%0d]", k), {31'd0, in_ready}, {31'd0, tbl[k].e_rdy});
            chk($sformatf("t1_rd[%0d]", k), {8'd0, rd_data}, {8'd0, tbl[k].e_rd});
            chk($sformatf("t1_swap[%0d]", k), {31'd0, swap_pulse}, {31'd0, tbl[k].e_sw});
            chk($sformatf("t1_frames[%0d]", k), {24'd0, frames_shown}, {24'd0, tbl[k].e_fr});
            tick();
        end

        // 2: partial frame does not swap
        do_reset();
        for (int i = 0; i < 10; i++) push(24'(100 + i), (i == 0));
        vs_edge(sw);
        chk("t2_noswap", {31'd0, sw}, 32'd0);
        chk("t2_frames0", {24'd0, frames_shown}, 32'd0);
        for (int a = 0; a < 16; a++) rd_chk($sformatf("t2_rd0[%0d]", a), 4'(a), 24'd0);
        for (int i = 10; i < 16; i++) push(24'(100 + i), 1'b0);
        vs_edge(sw);
        chk("t2_swap", {31'd0, sw}, 32'd1);
        chk("t2_frames1", {24'd0, frames_shown}, 32'd1);
        rd_chk("t2_rd3", 4'd3, 24'd103);
        rd_chk("t2_rd12", 4'd12, 24'd112);

        // 3: back-pressure while FULL, sof required after the swap
        for (int i = 0; i < 16; i++) push(24'(2000 + i), (i == 0));
        in_valid = 1'b1; in_sof = 1'b0; in_data = 24'h0000AA;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("t3_stall[%0d]", c), {31'd0, in_ready}, 32'd0);
            tick();
        end
        vsync = 1'b0;
        tick();
        chk("t3_swap", {31'd0, swap_pulse}, 32'd1);
        chk("t3_frames2", {24'd0, frames_shown}, 32'd2);
        chk("t3_ready_after", {31'd0, in_ready}, 32'd1);
        rd_chk("t3_rdA", 4'd5, 24'd2005);
        vsync = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) push(24'(3000 + i), (i == 0));
        chk("t3_no_resync", {24'd0, resync_errs}, 32'd0);
        rd_chk("t3_rdA_held", 4'd5, 24'd2005);
        vs_edge(sw);
        chk("t3_swapB", {31'd0, sw}, 32'd1);
        rd_chk("t3_rdB5", 4'd5, 24'd3005);
        rd_chk("t3_rdB0", 4'd0, 24'd3000);
        chk("t3_frames3", {24'd0, frames_shown}, 32'd3);

        // 4: resync at bin 5 with negative samples
        for (int i = 0; i < 5; i++) push(24'(50 + i), (i == 0));
        for (int i = 0; i < 16; i++) push(24'(-(i + 1)), (i == 0));
        chk("t4_resync", {24'd0, resync_errs}, 32'd1);
        vs_edge(sw);
        chk("t4_swap", {31'd0, sw}, 32'd1);
        rd_chk("t4_rd0", 4'd0, 24'hFFFFFF);
        rd_chk("t4_rd5", 4'd5, 24'hFFFFFA);
        rd_chk("t4_rd15", 4'd15, 24'hFFFFF0);
        chk("t4_frames4", {24'd0, frames_shown}, 32'd4);

        // 5: freeze holds the front bank across several vsync edges
        for (int i = 0; i < 16; i++) push(24'(4000 + i), (i == 0));
        freeze = 1'b1;
        for (int e = 0; e < 3; e++) begin
            vs_edge(sw);
            chk($sformatf("t5_noswap[%0d]", e), {31'd0, sw}, 32'd0);
            rd_chk($sformatf("t5_rd3[%0d]", e), 4'd3, 24'hFFFFFC);
            chk($sformatf("t5_frames[%0d]", e), {24'd0, frames_shown}, 32'd4);
            chk($sformatf("t5_ready[%0d]", e), {31'd0, in_ready}, 32'd0);
        end
        freeze = 1'b0;
        vs_edge(sw);
        chk("t5_swap", {31'd0, sw}, 32'd1);
        rd_chk("t5_rd3_new", 4'd3, 24'd4003);
        chk("t5_frames5", {24'd0, frames_shown}, 32'd5);

        // 6: reset mid-fill, then sof-less samples are dropped
        for (int i = 0; i < 8; i++) push(24'(7000 + i), (i == 0));
        rst = 1'b1;
        #1;
        chk("t6_ready_rst", {31'd0, in_ready}, 32'd0);
        tick();
        chk("t6_ready_rst2", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        rd_chk("t6_rd3", 4'd3, 24'd0);
        chk("t6_frames", {24'd0, frames_shown}, 32'd0);
        chk("t6_resync", {24'd0, resync_errs}, 32'd0);
        chk("t6_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 16; i++) push(24'(9000 + i), 1'b0);
        vs_edge(sw);
        chk("t6_nosof_noswap", {31'd0, sw}, 32'd0);
        for (int i = 0; i < 16; i++) push(24'(8000 + i), (i == 0));
        vs_edge(sw);
        chk("t6_swap", {31'd0, sw}, 32'd1);
        rd_chk("t6_rd2", 4'd2, 24'd8002);
        chk("t6_frames1", {24'd0, frames_shown}, 32'd1);

        // 7: bin 15 accepted on the vsync falling edge swaps only on the next edge
        for (int i = 0; i < 15; i++) push(24'(500 + i), (i == 0));
        vsync = 1'b0;
        push(24'd515, 1'b0);
        chk("t7_noswap", {31'd0, swap_pulse}, 32'd0);
        rd_chk("t7_rd_old", 4'd2, 24'd8002);
        vsync = 1'b1;
        tick();
        vs_edge(sw);
        chk("t7_swap", {31'd0, sw}, 32'd1);
        rd_chk("t7_rd15", 4'd15, 24'd515);
        chk("t7_frames2", {24'd0, frames_shown}, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
